// File: rtl/wb_pkg.sv
// Shared widths, arbiter source select and the write request record used
// by the register-file write-side front end.
package wb_pkg;

   localparam int XLEN     = 32;
   localparam int REG_AW   = 5;
   localparam int NUM_REGS = 1 << REG_AW;

   typedef enum logic [1:0] {
      WB_NONE,
      WB_ALU,
      WB_LOAD
   } wb_src_e;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_req_t;

   // x0 never reads as pending, whatever its scoreboard bit holds.
   function automatic logic reg_hit(input logic [NUM_REGS-1:0] bits,
                                    input logic [REG_AW-1:0]   r);
      return (r != '0) && bits[r];
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for buffered load returns; pointers carry one extra
// wrap bit so full and empty are told apart without a separate flag.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = wb_req_t
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  T                         wdata,
   output T                         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   T            mem [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop && !empty) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Storage needs no reset: an entry is only read after it was written.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[wr_ptr[AW-1:0]] <= wdata;
      end
   end

   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (count == (AW+1)'(DEPTH));
   assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/wb_arbiter.sv
// Write-side front end of the register file: merges ALU results and
// buffered load returns onto one write port and tracks pending loads.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [REG_AW-1:0] alu_rd,
   input  logic [XLEN-1:0]   alu_data,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [REG_AW-1:0] ld_rd,
   input  logic [XLEN-1:0]   ld_data,
   input  logic              iss_valid,
   input  logic [REG_AW-1:0] iss_rd,
   input  logic [REG_AW-1:0] chk_rs1,
   input  logic [REG_AW-1:0] chk_rs2,
   output logic              stall,
   output logic              w_en,
   output logic [REG_AW-1:0] rd,
   output logic [XLEN-1:0]   rdv
);

   localparam int FAW = $clog2(FIFO_DEPTH);
   localparam int SW  = $clog2(STARVE_MAX + 1);

   logic [NUM_REGS-1:0] pend;
   logic [NUM_REGS-1:0] pend_next;
   logic [SW-1:0]       starve_cnt;
   logic [SW-1:0]       starve_next;
   wb_src_e             out_src;
   wb_src_e             src_sel;
   wb_req_t             out_req;
   wb_req_t             out_next;
   wb_req_t             fifo_head;
   wb_req_t             ld_req;
   logic                alu_win;
   logic                fifo_push;
   logic                fifo_pop;
   logic                fifo_full;
   logic                fifo_empty;
   logic [FAW:0]        fifo_count;

   assign ld_req    = '{rd: ld_rd, data: ld_data};
   assign fifo_push = ld_valid && !fifo_full && (ld_rd != '0);
   assign ld_ready  = (fifo_count < (FAW+1)'(FIFO_DEPTH));

   wb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (wb_req_t)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (ld_req),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // A forced drain needs no special case: with alu_ready low the ALU
   // cannot win, so a non-empty FIFO pops that cycle.
   always_comb begin
      alu_win  = alu_valid && alu_ready && (alu_rd != '0);
      fifo_pop = !alu_win && !fifo_empty;
      src_sel  = WB_NONE;
      out_next = '0;
      if (alu_win) begin
         src_sel  = WB_ALU;
         out_next = '{rd: alu_rd, data: alu_data};
      end else if (fifo_pop) begin
         src_sel  = WB_LOAD;
         out_next = fifo_head;
      end
      starve_next = (alu_win && !fifo_empty) ? starve_cnt + 1'b1 : '0;
   end

   // The clear targets the load currently on the outputs; an issue to the
   // same register in that cycle is applied last so it wins.
   always_comb begin
      pend_next = pend;
      if (out_src == WB_LOAD) begin
         pend_next[out_req.rd] = 1'b0;
      end
      if (iss_valid && (iss_rd != '0)) begin
         pend_next[iss_rd] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_src    <= WB_NONE;
         out_req    <= '0;
         pend       <= '0;
         starve_cnt <= '0;
         alu_ready  <= 1'b1;
      end else begin
         out_src    <= src_sel;
         out_req    <= out_next;
         pend       <= pend_next;
         starve_cnt <= starve_next;
         alu_ready  <= (starve_next != SW'(STARVE_MAX));
      end
   end

   assign w_en  = (out_src != WB_NONE);
   assign rd    = out_req.rd;
   assign rdv   = out_req.data;
   assign stall = reg_hit(pend, chk_rs1) || reg_hit(pend, chk_rs2);

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, multi-cycle corner sequences
// and randomized traffic against a queue-based reference model.
module tb_wb_arbiter;
   import wb_pkg::*;

   localparam int DEPTH = 4;
   localparam int SMAX  = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        ld_valid;
   logic        ld_ready;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic [4:0]  chk_rs1;
   logic [4:0]  chk_rs2;
   logic        stall;
   logic        w_en;
   logic [4:0]  rd;
   logic [31:0] rdv;

   always #5 clk = ~clk;

   wb_arbiter #(
      .FIFO_DEPTH (DEPTH),
      .STARVE_MAX (SMAX)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .ld_valid  (ld_valid),
      .ld_ready  (ld_ready),
      .ld_rd     (ld_rd),
      .ld_data   (ld_data),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .chk_rs1   (chk_rs1),
      .chk_rs2   (chk_rs2),
      .stall     (stall),
      .w_en      (w_en),
      .rd        (rd),
      .rdv       (rdv)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: buffered loads as a queue, pending set as a bit vector,
   // starvation as a plain count of ALU wins over a waiting load.
   wb_req_t     mq[$];
   logic [31:0] mpend;
   int          mstarve;
   logic        m_alu_ready;
   logic        m_w_en;
   logic        m_load;
   logic [4:0]  m_rd;
   logic [31:0] m_rdv;

   typedef struct {
      logic        av;  logic [4:0] ar;  logic [31:0] ad;
      logic        lv;  logic [4:0] lr;  logic [31:0] ldd;
      logic        iv;  logic [4:0] ir;
      logic [4:0]  c1;  logic [4:0] c2;
      logic        e_ar; logic e_lr; logic e_st; logic e_wen;
      logic [4:0]  e_rd; logic [31:0] e_rdv;
   } vec_t;

   vec_t        vecs[$];
   logic [4:0]  outst[$];

   function automatic vec_t mkv(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                                input logic lv, input logic [4:0] lr, input logic [31:0] ldd,
                                input logic iv, input logic [4:0] ir,
                                input logic [4:0] c1, input logic [4:0] c2,
                                input logic e_ar, input logic e_lr, input logic e_st,
                                input logic e_wen, input logic [4:0] e_rd, input logic [31:0] e_rdv);
      vec_t v;
      v.av = av; v.ar = ar; v.ad = ad; v.lv = lv; v.lr = lr; v.ldd = ldd;
      v.iv = iv; v.ir = ir; v.c1 = c1; v.c2 = c2;
      v.e_ar = e_ar; v.e_lr = e_lr; v.e_st = e_st; v.e_wen = e_wen; v.e_rd = e_rd; v.e_rdv = e_rdv;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic model_stall(input logic [4:0] a, input logic [4:0] b);
      return ((a != 5'd0) && mpend[a]) || ((b != 5'd0) && mpend[b]);
   endfunction

   task automatic model_reset();
      mq.delete();
      mpend       = 32'd0;
      mstarve     = 0;
      m_alu_ready = 1'b1;
      m_w_en      = 1'b0;
      m_load      = 1'b0;
      m_rd        = 5'd0;
      m_rdv       = 32'd0;
   endtask

   task automatic model_step();
      logic        win;
      logic        popit;
      logic        ld_rdy;
      logic [31:0] np;
      wb_req_t     head;
      ld_rdy = (mq.size() < DEPTH);
      if (iss_valid && iss_rd != 5'd0)
         assert (!mpend[iss_rd] || (m_load && m_rd == iss_rd))
            else $error("[TB] load issued to register x%0d that already has a pending load", iss_rd);
      win     = alu_valid && m_alu_ready && (alu_rd != 5'd0);
      popit   = !win && (mq.size() != 0);
      mstarve = (win && mq.size() != 0) ? mstarve + 1 : 0;
      np = mpend;
      if (m_load) np[m_rd] = 1'b0;
      if (iss_valid && iss_rd != 5'd0) np[iss_rd] = 1'b1;
      mpend = np;
      if (win) begin
         m_w_en = 1'b1; m_load = 1'b0; m_rd = alu_rd; m_rdv = alu_data;
      end else if (popit) begin
         head   = mq.pop_front();
         m_w_en = 1'b1; m_load = 1'b1; m_rd = head.rd; m_rdv = head.data;
      end else begin
         m_w_en = 1'b0; m_load = 1'b0; m_rd = 5'd0; m_rdv = 32'd0;
      end
      if (ld_valid && ld_rdy && ld_rd != 5'd0) begin
         head.rd   = ld_rd;
         head.data = ld_data;
         mq.push_back(head);
      end
      m_alu_ready = (mstarve != SMAX);
   endtask

   task automatic check_output();
      check("alu_ready", 32'(alu_ready), 32'(m_alu_ready));
      check("ld_ready",  32'(ld_ready),  32'(mq.size() < DEPTH));
      check("stall",     32'(stall),     32'(model_stall(chk_rs1, chk_rs2)));
      check("w_en",      32'(w_en),      32'(m_w_en));
      check("rd",        32'(rd),        32'(m_rd));
      check("rdv",       rdv,            m_rdv);
      check("pend",      dut.pend,       mpend);
   endtask

   // Inputs are already applied; settle, compare, advance model and clock.
   task automatic cycle();
      #1;
      check_output();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
      ld_valid  = 1'b0; ld_rd  = 5'd0; ld_data  = 32'd0;
      iss_valid = 1'b0; iss_rd = 5'd0;
      chk_rs1   = 5'd0; chk_rs2 = 5'd0;
   endtask

   task automatic apply_stimulus(input vec_t v);
      alu_valid = v.av; alu_rd = v.ar; alu_data = v.ad;
      ld_valid  = v.lv; ld_rd  = v.lr; ld_data  = v.ldd;
      iss_valid = v.iv; iss_rd = v.ir;
      chk_rs1   = v.c1; chk_rs2 = v.c2;
   endtask

   initial begin
      // ALU path, x0 discard, load/scoreboard timing on both check ports.
      vecs.push_back(mkv(1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    1'b0,5'd0, 5'd0,5'd0, 1'b1,1'b1,1'b0,1'b0,5'd0,32'h0));
      vecs.push_back(mkv(1'b1,5'd5,32'hDEADBEEF, 1'b0,5'd0,32'h0,    1'b0,5'd0, 5'd0,5'd0, 1'b1,1'b1,1'b0,1'b0,5'd0,32'h0));
      vecs.push_back(mkv(1'b1,5'd0,32'h1111,     1'b0,5'd0,32'h0,    1'b0,5'd0, 5'd0,5'd0, 1'b1,1'b1,1'b0,1'b1,5'd5,32'hDEADBEEF));
      vecs.push_back(mkv(1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    1'b1,5'd7, 5'd0,5'd0, 1'b1,1'b1,1'b0,1'b0,5'd0,32'h0));
      vecs.push_back(mkv(1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    1'b0,5'd0, 5'd7,5'd0, 1'b1,1'b1,1'b1,1'b0,5'd0,32'h0));
      vecs.push_back(mkv(1'b0,5'd0,32'h0,        1'b1,5'd7,32'h1234, 1'b0,5'd0, 5'd7,5'd0, 1'b1,1'b1,1'b1,1'b0,5'd0,32'h0));
      vecs.push_back(mkv(1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    1'b0,5'd0, 5'd7,5'd0, 1'b1,1'b1,1'b1,1'b0,5'd0,32'h0));
      vecs.push_back(mkv(1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    1'b0,5'd0, 5'd7,5'd0, 1'b1,1'b1,1'b1,1'b1,5'd7,32'h1234));
      vecs.push_back(mkv(1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    1'b0,5'd0, 5'd7,5'd7, 1'b1,1'b1,1'b0,1'b0,5'd0,32'h0));
      vecs.push_back(mkv(1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    1'b1,5'd3, 5'd0,5'd0, 1'b1,1'b1,1'b0,1'b0,5'd0,32'h0));
      vecs.push_back(mkv(1'b0,5'd0,32'h0,        1'b1,5'd3,32'hABCD, 1'b0,5'd0, 5'd0,5'd3, 1'b1,1'b1,1'b1,1'b0,5'd0,32'h0));
      vecs.push_back(mkv(1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    1'b0,5'd0, 5'd3,5'd0, 1'b1,1'b1,1'b1,1'b0,5'd0,32'h0));
      vecs.push_back(mkv(1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    1'b0,5'd0, 5'd0,5'd0, 1'b1,1'b1,1'b0,1'b1,5'd3,32'hABCD));
      vecs.push_back(mkv(1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    1'b0,5'd0, 5'd0,5'd3, 1'b1,1'b1,1'b0,1'b0,5'd0,32'h0));
      vecs.push_back(mkv(1'b0,5'd0,32'h0,        1'b1,5'd0,32'h5,    1'b0,5'd0, 5'd0,5'd0, 1'b1,1'b1,1'b0,1'b0,5'd0,32'h0));
      vecs.push_back(mkv(1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    1'b0,5'd0, 5'd0,5'd0, 1'b1,1'b1,1'b0,1'b0,5'd0,32'h0));
      vecs.push_back(mkv(1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    1'b0,5'd0, 5'd0,5'd0, 1'b1,1'b1,1'b0,1'b0,5'd0,32'h0));

      rst = 1'b1;
      idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         apply_stimulus(vecs[i]);
         #1;
         check($sformatf("vec%0d alu_ready", i), 32'(alu_ready), 32'(vecs[i].e_ar));
         check($sformatf("vec%0d ld_ready", i),  32'(ld_ready),  32'(vecs[i].e_lr));
         check($sformatf("vec%0d stall", i),     32'(stall),     32'(vecs[i].e_st));
         check($sformatf("vec%0d w_en", i),      32'(w_en),      32'(vecs[i].e_wen));
         check($sformatf("vec%0d rd", i),        32'(rd),        32'(vecs[i].e_rd));
         check($sformatf("vec%0d rdv", i),       rdv,            vecs[i].e_rdv);
         cycle();
      end

      // Starvation: one queued load behind three ALU wins.
      idle(); iss_valid = 1'b1; iss_rd = 5'd12; cycle(); idle();
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'd100;
      ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'hC0;
      cycle();
      ld_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         alu_rd = 5'(k + 1); alu_data = 32'(100 + k);
         #1; check("starve ready before limit", 32'(alu_ready), 32'd1);
         cycle();
      end
      alu_rd = 5'd5; alu_data = 32'd500;
      #1; check("starve ready forced low", 32'(alu_ready), 32'd0);
      cycle();
      #1;
      check("starve ready restored", 32'(alu_ready), 32'd1);
      check("starve drain w_en", 32'(w_en), 32'd1);
      check("starve drain rd", 32'(rd), 32'd12);
      check("starve drain rdv", rdv, 32'hC0);
      cycle();
      alu_valid = 1'b0;
      #1; check("starve held alu rd", 32'(rd), 32'd5);
      cycle();

      // Full FIFO: four loads under ALU pressure, fifth held until a pop.
      for (int k = 0; k < 5; k++) begin
         idle(); iss_valid = 1'b1; iss_rd = 5'(10 + k); cycle();
      end
      idle();
      alu_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         alu_rd = 5'(20 + k); alu_data = 32'(k);
         ld_valid = 1'b1; ld_rd = 5'(10 + k); ld_data = 32'(32'h100 + k);
         #1; check("fill ld_ready", 32'(ld_ready), 32'd1);
         cycle();
      end
      alu_rd = 5'd24; alu_data = 32'h24;
      ld_rd = 5'd14; ld_data = 32'h104;
      #1;
      check("full ld_ready low", 32'(ld_ready), 32'd0);
      check("full alu_ready low", 32'(alu_ready), 32'd0);
      cycle();
      #1;
      check("after pop ld_ready", 32'(ld_ready), 32'd1);
      check("first drained rd", 32'(rd), 32'd10);
      check("first drained rdv", rdv, 32'h100);
      cycle();
      idle();
      #1; check("alu after fill rd", 32'(rd), 32'd24);
      cycle();
      for (int k = 0; k < 4; k++) begin
         #1;
         check("drain order w_en", 32'(w_en), 32'd1);
         check("drain order rd", 32'(rd), 32'(11 + k));
         check("drain order rdv", rdv, 32'(32'h101 + k));
         cycle();
      end

      // Same-cycle clear and re-issue of x9.
      idle(); iss_valid = 1'b1; iss_rd = 5'd9; cycle(); idle();
      ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99; cycle(); idle();
      cycle();
      iss_valid = 1'b1; iss_rd = 5'd9;
      #1; check("x9 write rd", 32'(rd), 32'd9);
      cycle(); idle();
      chk_rs1 = 5'd9;
      #1;
      check("x9 reissue stall", 32'(stall), 32'd1);
      check("x9 reissue pend", 32'(dut.pend[9]), 32'd1);
      cycle();

      // Mid-stream reset with three buffered loads and pend = 0x104.
      idle(); iss_valid = 1'b1; iss_rd = 5'd2; cycle();
      iss_rd = 5'd8; cycle(); idle();
      alu_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         alu_rd = 5'(1 + k); alu_data = 32'(k);
         ld_valid = 1'b1; ld_rd = (k == 0) ? 5'd2 : (k == 1) ? 5'd8 : 5'd20; ld_data = 32'(k + 7);
         cycle();
      end
      idle();
      chk_rs1 = 5'd2; chk_rs2 = 5'd8;
      #1; check("pre-reset pend", dut.pend & 32'hFFFF_FDFF, 32'h0000_0104);
      rst = 1'b1;
      #1;
      check("reset w_en", 32'(w_en), 32'd0);
      check("reset rd", 32'(rd), 32'd0);
      check("reset rdv", rdv, 32'd0);
      check("reset stall", 32'(stall), 32'd0);
      check("reset pend", dut.pend, 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset ld_ready", 32'(ld_ready), 32'd1);
      check("reset alu_ready", 32'(alu_ready), 32'd1);
      cycle();
      #1; check("reset discarded fifo", 32'(w_en), 32'd0);
      cycle();

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         int         idx;
         logic [4:0] r;
         idle();
         alu_valid = ($urandom_range(0, 99) < 55);
         alu_rd    = 5'($urandom_range(0, 31));
         alu_data  = $urandom;
         if (outst.size() > 0 && $urandom_range(0, 99) < 45) begin
            idx = $urandom_range(0, outst.size() - 1);
            ld_valid = 1'b1; ld_rd = outst[idx]; ld_data = $urandom;
            if (mq.size() < DEPTH) outst.delete(idx);
         end else if ($urandom_range(0, 19) == 0) begin
            ld_valid = 1'b1; ld_rd = 5'd0; ld_data = $urandom;
         end
         if ($urandom_range(0, 99) < 30) begin
            r = 5'($urandom_range(0, 31));
            if (r == 5'd0) begin
               iss_valid = 1'b1; iss_rd = 5'd0;
            end else if (!mpend[r]) begin
               iss_valid = 1'b1; iss_rd = r;
               outst.push_back(r);
            end
         end
         chk_rs1 = 5'($urandom_range(0, 31));
         chk_rs2 = 5'($urandom_range(0, 31));
         cycle();
      end
      idle();
      repeat (8) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-side front end for the 32x32 register file in the single-issue core.
- Merges single-cycle ALU results and variable-latency load returns onto the register file's single write port (`w_en`/`rd`/`rdv`).
- Buffers load returns in a small FIFO.
- Tracks a pending-load scoreboard that the decode stage uses to stall reads of registers whose load has not yet been written back.

## Interface
Parameters:
- `FIFO_DEPTH`, 4 — load-return buffer entries; power of two, ≥2.
- `STARVE_MAX`, 3 — consecutive ALU-won cycles with a non-empty FIFO before a forced drain.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `alu_valid`  in  1  — ALU result offered.
- `alu_ready`  out  1  — ALU result accepted when `alu_valid & alu_ready`.
- `alu_rd`  in  5  — ALU destination register.
- `alu_data`  in  32  — ALU result.
- `ld_valid`  in  1  — load return offered.
- `ld_ready`  out  1  — FIFO not full.
- `ld_rd`  in  5  — load destination register.
- `ld_data`  in  32  — load data.
- `iss_valid`  in  1  — a load is issuing this cycle.
- `iss_rd`  in  5  — destination of the issuing load.
- `chk_rs1`  in  5  — decode source register 1.
- `chk_rs2`  in  5  — decode source register 2.
- `stall`  out  1  — a source register has a pending load.
- `w_en`  out  1  — register file write enable.
- `rd`  out  5  — register file write address.
- `rdv`  out  32  — register file write data.

## Operation
- **ALU writes.** An accepted ALU result with `alu_rd != 0` is written.
  - `alu_rd == 0` is accepted and discarded: `w_en` stays low and the slot counts as idle.
- **Load returns.** An accepted load return is pushed into the FIFO.
  - `ld_rd == 0` is accepted and not pushed.
- **Arbitration.** Each cycle, in priority order:
  1. `alu_valid & alu_ready` with `alu_rd != 0` → ALU write.
  2. Otherwise, FIFO non-empty → pop the head and write it.
  3. Otherwise, no write.
- **Starvation counter.**
  - Increments on each cycle where the ALU wins while the FIFO is non-empty.
  - Clears on any FIFO pop and whenever the FIFO is empty.
  - When the counter equals `STARVE_MAX`, `alu_ready` is low for exactly one cycle and the FIFO head is written that cycle. The counter then clears.
- **Scoreboard** (`pend[31:0]`):
  - `iss_valid` with `iss_rd != 0` sets `pend[iss_rd]`.
  - A FIFO-sourced write clears the bit for its `rd`.
  - Set and clear of the same index in the same cycle → bit ends set.
  - Issuing to an already-pending `rd` is illegal; the bench flags it as an assertion.
- **Stall.** `stall = (chk_rs1 != 0 & pend[chk_rs1]) | (chk_rs2 != 0 & pend[chk_rs2])`.
  - Combinational; it sees `pend` as registered at the start of the cycle.

## Timing
- Reset values:
  - `w_en` = 0, `rd` = 0, `rdv` = 0.
  - `alu_ready` = 1, `ld_ready` = 1, `stall` = 0.
  - `pend` = 0, FIFO empty, starvation counter = 0.
- Reset asserted mid-operation discards FIFO contents and the scoreboard immediately.
- `w_en`/`rd`/`rdv` are registered.
  - ALU result accepted in cycle N → driven in cycle N+1 → committed at the end of N+1.
  - Load accepted in cycle N → earliest drive in cycle N+2 (push at end of N, pop decision in N+1).
- `pend` bit clears at the end of the cycle in which the load's write is driven on the outputs.
  - The register file forwards `rdv` during that same cycle, so `stall` may drop one cycle later with no hazard.
- `ld_ready` = (FIFO count < `FIFO_DEPTH`), registered from the count.
  - When full, it stays low in a same-cycle pop; there is no full-pass-through.
- FIFO pointers are `$clog2(FIFO_DEPTH)+1` bits wide; the MSB distinguishes full from empty, and pointers wrap modulo 2×`FIFO_DEPTH`.
- `alu_ready` is registered: it is computed from the counter at the end of the previous cycle.
- `alu_valid` while `alu_ready` is low is not accepted; upstream must hold its data.

## Structure
- Package `wb_pkg`:
  - `XLEN` = 32, `REG_AW` = 5.
  - Enum `wb_src_e {WB_NONE, WB_ALU, WB_LOAD}` for the arbiter select.
  - Packed struct `wb_req_t {rd, data}` used for FIFO entries and the output register.
- Sub-module `wb_fifo`: synchronous FIFO parameterized by depth and entry type, with `push`/`pop`/`full`/`empty`/`count`.
- `wb_arbiter` holds the priority logic, starvation counter, scoreboard and output register.

## Test plan
- **Reset:** assert `rst` mid-stream with 3 FIFO entries and `pend` = 0x0000_0104 → next cycle all outputs at reset values, `pend` = 0, `ld_ready` = 1.
- **ALU path:** `alu_valid`, `alu_rd` = 5, `alu_data` = 0xDEAD_BEEF in cycle N → `w_en` = 1, `rd` = 5, `rdv` = 0xDEAD_BEEF in N+1. With `alu_rd` = 0 → `w_en` = 0.
- **Load and scoreboard:** issue load to x7, then `chk_rs1` = 7 → `stall` = 1. Load return 0x1234 accepted in N → write in N+2; `stall` = 0 in N+3.
- **Starvation:** continuous ALU writes with one queued load, `STARVE_MAX` = 3 → `alu_ready` low for exactly one cycle after 3 ALU wins; load is written in that cycle.
- **Full FIFO:** 4 loads pushed while ALU saturates → `ld_ready` = 0 on the 4th push's next cycle. A fifth `ld_valid` is held, then accepted after the first pop. Entries drain in FIFO order.
- **Same-cycle set/clear:** FIFO writes x9 while `iss_valid`, `iss_rd` = 9 → `pend[9]` = 1 afterward.
